// File: rtl/mic1_io_pkg.sv
// Shared types and constants for the mic1 console peripheral.
package mic1_io_pkg;

   localparam logic [31:0] IO_ADDR_DEFAULT = 32'hFFFF_FFFD;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } uart_tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } uart_rx_state_t;

endpackage

// File: rtl/mic1_io_fifo.sv
// Small show-ahead synchronous FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module mic1_io_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign rdata_o = mem_q[rd_ptr_q];

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is left unreset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/mic1_io_console.sv
// Memory-mapped console: bus writes to IO_ADDR queue bytes for an 8N1 transmitter,
// bus reads return the last byte received on ser_rx (or 0 when nothing is pending).
module mic1_io_console
   import mic1_io_pkg::*;
#(
   parameter logic [31:0] IO_ADDR       = IO_ADDR_DEFAULT,
   parameter int          CLKS_PER_BIT  = 16,
   parameter int          TX_FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        ser_tx,
   input  logic        ser_rx,
   output logic        tx_busy,
   output logic        tx_overflow,
   output logic        rx_overrun
);

   localparam int             CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]  CNT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]  CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);

   logic hit, wr_hit, rd_hit;
   logic unused_wdata;

   assign hit          = (mem_addr == IO_ADDR);
   assign wr_hit       = mem_write && hit;
   assign rd_hit       = mem_read && hit;
   assign unused_wdata = ^mem_wdata[31:8];

   // ---------------- TX FIFO ----------------
   logic       fifo_pop, fifo_full, fifo_empty;
   logic [7:0] fifo_rdata;

   mic1_io_fifo #(
      .DEPTH (TX_FIFO_DEPTH),
      .WIDTH (8)
   ) u_tx_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (wr_hit),
      .pop_i   (fifo_pop),
      .wdata_i (mem_wdata[7:0]),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // ---------------- TX serializer ----------------
   uart_tx_state_t tx_state_q, tx_state_d;
   logic [CW-1:0]  tx_cnt_q, tx_cnt_d;
   logic [2:0]     tx_bit_q, tx_bit_d;
   logic [7:0]     tx_shift_q, tx_shift_d;
   logic           tx_bit_end;
   logic           tx_overflow_q, tx_overflow_d;

   assign tx_bit_end = (tx_cnt_q == CNT_LAST);

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      fifo_pop   = 1'b0;
      if (tx_state_q != TX_IDLE) begin
         tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + CW'(1);
      end
      case (tx_state_q)
         TX_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               tx_shift_d = fifo_rdata;
               tx_cnt_d   = '0;
               tx_state_d = TX_START;
            end
         end
         TX_START: begin
            if (tx_bit_end) begin
               tx_bit_d   = 3'd0;
               tx_state_d = TX_DATA;
            end
         end
         TX_DATA: begin
            if (tx_bit_end) begin
               tx_shift_d = {1'b1, tx_shift_q[7:1]};
               if (tx_bit_q == 3'd7) begin
                  tx_state_d = TX_STOP;
               end else begin
                  tx_bit_d = tx_bit_q + 3'd1;
               end
            end
         end
         TX_STOP: begin
            // Chain straight into the next frame so queued bytes go out with no idle gap.
            if (tx_bit_end) begin
               if (!fifo_empty) begin
                  fifo_pop   = 1'b1;
                  tx_shift_d = fifo_rdata;
                  tx_state_d = TX_START;
               end else begin
                  tx_state_d = TX_IDLE;
               end
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   assign tx_overflow_d = tx_overflow_q || (wr_hit && fifo_full && !fifo_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state_q    <= TX_IDLE;
         tx_cnt_q      <= '0;
         tx_bit_q      <= '0;
         tx_shift_q    <= '0;
         tx_overflow_q <= 1'b0;
      end else begin
         tx_state_q    <= tx_state_d;
         tx_cnt_q      <= tx_cnt_d;
         tx_bit_q      <= tx_bit_d;
         tx_shift_q    <= tx_shift_d;
         tx_overflow_q <= tx_overflow_d;
      end
   end

   always_comb begin
      case (tx_state_q)
         TX_START: ser_tx = 1'b0;
         TX_DATA:  ser_tx = tx_shift_q[0];
         default:  ser_tx = 1'b1;
      endcase
   end

   assign tx_busy     = !fifo_empty || (tx_state_q != TX_IDLE);
   assign tx_overflow = tx_overflow_q;

   // ---------------- RX deserializer ----------------
   logic [1:0]     rx_sync_q;
   logic           rx_prev_q;
   logic           rx_line;
   uart_rx_state_t rx_state_q, rx_state_d;
   logic [CW-1:0]  rx_cnt_q, rx_cnt_d;
   logic [2:0]     rx_bit_q, rx_bit_d;
   logic [7:0]     rx_shift_q, rx_shift_d;
   logic           rx_land;

   assign rx_line = rx_sync_q[1];

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q + CW'(1);
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_land    = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            rx_cnt_d = '0;
            if (rx_prev_q && !rx_line) begin
               rx_state_d = RX_START;
            end
         end
         RX_START: begin
            if (rx_cnt_q == CNT_HALF) begin
               rx_cnt_d   = '0;
               rx_bit_d   = 3'd0;
               rx_state_d = rx_line ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == CNT_LAST) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_line, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) begin
                  rx_state_d = RX_STOP;
               end else begin
                  rx_bit_d = rx_bit_q + 3'd1;
               end
            end
         end
         RX_STOP: begin
            // A low stop bit is a framing error: the byte is silently dropped.
            if (rx_cnt_q == CNT_LAST) begin
               rx_cnt_d   = '0;
               rx_land    = rx_line;
               rx_state_d = RX_IDLE;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_sync_q  <= 2'b11;
         rx_prev_q  <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
      end else begin
         rx_sync_q  <= {rx_sync_q[0], ser_rx};
         rx_prev_q  <= rx_line;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
      end
   end

   // ---------------- Holding and read-data registers ----------------
   logic [7:0]  rx_byte_q, rx_byte_d;
   logic        rx_valid_q, rx_valid_d;
   logic        rx_overrun_q, rx_overrun_d;
   logic [31:0] rdata_q, rdata_d;

   // A read in the landing cycle returns the old byte and the new byte stays pending.
   always_comb begin
      rx_byte_d    = rx_byte_q;
      rx_valid_d   = rx_valid_q;
      rx_overrun_d = rx_overrun_q;
      rdata_d      = rdata_q;
      if (rd_hit) begin
         rdata_d    = rx_valid_q ? {24'h0, rx_byte_q} : 32'h0;
         rx_valid_d = 1'b0;
      end
      if (rx_land) begin
         rx_byte_d  = rx_shift_q;
         rx_valid_d = 1'b1;
         if (rx_valid_q && !rd_hit) begin
            rx_overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_byte_q    <= '0;
         rx_valid_q   <= 1'b0;
         rx_overrun_q <= 1'b0;
         rdata_q      <= '0;
      end else begin
         rx_byte_q    <= rx_byte_d;
         rx_valid_q   <= rx_valid_d;
         rx_overrun_q <= rx_overrun_d;
         rdata_q      <= rdata_d;
      end
   end

   assign mem_rdata  = rdata_q;
   assign rx_overrun = rx_overrun_q;

endmodule
